formula_pipe_credit_adapter: RTL and testbench
==============================================

Name: formula_pipe_credit_adapter

Overview:
- Sink/issue-side companion to the valid-only formula pipes, whose interface is arg_vld/a/b/c in and res_vld/res out, with no backpressure.
- Accepts argument triples from a valid/ready upstream and issues them to the pipe.
- Captures every pipe result into an internal FIFO and presents the results to a valid/ready downstream.
- Credit counting guarantees the FIFO never overflows, so the pipe never has to stall.

Parameters:
- W, 32, data width of a, b, c and res.
- DEPTH, 8, result FIFO depth; equals the initial credit count; power of two, ≥ 2.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset.
- up_vld, input, 1, upstream argument triple valid.
- up_rdy, output, 1, adapter can accept a triple.
- up_a / up_b / up_c, input, W each, upstream arguments.
- arg_vld, output, 1, issue strobe to the pipe.
- a / b / c, output, W each, arguments to the pipe.
- res_vld, input, 1, pipe result strobe.
- res, input, W, pipe result.
- down_vld, output, 1, result available.
- down_rdy, input, 1, downstream accepts.
- down_data, output, W, result at the FIFO head.
- credits, output, $clog2(DEPTH)+1, current credit count.
- in_flight, output, $clog2(DEPTH)+1, issued but not yet returned.
- err_overflow, output, 1, sticky: push into a full FIFO.
- err_unexpected, output, 1, sticky: res_vld while in_flight == 0.

Behaviour:
- Clocking and reset
  - Single clock.
  - Reset is synchronous and active-high on rst.
- Reset values
  - arg_vld=0, a/b/c=0, credits=DEPTH, in_flight=0, FIFO empty.
  - down_vld=0, err_overflow=0, err_unexpected=0.
  - up_rdy=1 in the first cycle after reset.
- Upstream side
  - up_rdy = (credits != 0); registered credit only, never combinationally dependent on up_vld or down_rdy.
  - issue = up_vld & up_rdy.
- Issue register
  - On issue: arg_vld<=1, a/b/c<=up_a/up_b/up_c at the next edge.
  - Otherwise arg_vld<=0 and a/b/c hold their values.
  - Adapter adds exactly 1 cycle of issue latency.
- Credits
  - pop = down_vld & down_rdy.
  - Next credits = credits − issue + pop.
  - Simultaneous issue and pop: credits unchanged.
  - A credit freed by a pop is usable from the following cycle.
- in_flight
  - Next in_flight = in_flight + issue − (res_vld & in_flight != 0).
  - Counted from issue, not from arg_vld.
- Result FIFO
  - Show-ahead; push on res_vld.
  - down_vld = !empty; down_data = head entry.
  - Push and pop in the same cycle are allowed when full, when empty with push (data not visible until the next cycle), and in any other state.
- Boundary conditions
  - res_vld while the FIFO is full and no pop occurs: result dropped, err_overflow=1.
  - res_vld while in_flight == 0: result dropped, no push, err_unexpected=1.
  - Both error flags stay set until rst.
- Invariant: credits + in_flight + fifo_count == DEPTH every cycle while no error flag is set.
- Reset mid-operation
  - All state is restored to reset values and queued results are discarded.
  - The pipe shares rst, so no stale results are expected; any that arrive are flagged by err_unexpected.
- Throughput
  - Sustained 1 triple/cycle with down_rdy=1 requires DEPTH ≥ L + 2, where L is the pipe latency.
  - Smaller DEPTH throttles up_rdy and is never a functional error.
- Ordering: results leave in issue order; no reordering.

Decomposition:
- formula_pipe_pkg holds W, a word_t typedef (logic [W-1:0]) and DEFAULT_DEPTH; it is shared with the formula pipes.
- One sub-module: sync_fifo_show_ahead (parameters W, DEPTH).
  - Ports: push, push_data, pop, head_data, empty, full.
  - Implemented with flip-flops and a count register.
- Credit logic, in_flight counter and error logic live in the top module.

Test Plan:
- Reset check: hold rst 2 cycles, release -> up_rdy=1, credits=8, in_flight=0, down_vld=0, arg_vld=0, both error flags 0.
- Single transaction: a=2, b=1, c=9 with a latency-5 formula_2 model -> arg_vld pulses 1 cycle after acceptance with 2/1/9; down_vld rises with down_data=2; credits returns to 8 after the pop.
- Stalled downstream: down_rdy=0 with 12 back-to-back triples (a=14, b=7, c=4 for the first, then random) -> exactly 8 accepted, up_rdy=0 after the 8th, first result 4, FIFO full, no overflow. Then down_rdy=1 -> 8 results drain in order and the remaining 4 are accepted.
- Full rate: DEPTH=16, L=10, down_rdy=1, 200 consecutive random triples -> up_rdy never drops after the first cycle, one result per cycle, all results match the reference model, invariant holds every cycle.
- Boundary: credits=0 with a pop and up_vld in the same cycle -> no issue that cycle, issue on the next. Random down_rdy (50%) with 1000 triples -> no loss or duplication.
- Errors and reset: inject res_vld with in_flight=0 -> err_unexpected=1, no push. Assert rst with 5 in flight and 3 queued -> all state returns to reset values.

Source files
------------

// File: rtl/formula_pipe_pkg.sv
// formula_pipe_pkg: shared data width, word type and default result depth for the formula pipes.
package formula_pipe_pkg;
    localparam int W = 32;
    localparam int DEFAULT_DEPTH = 8;
    typedef logic [W-1:0] word_t;
endpackage

// File: rtl/formula_pipe_credit_adapter_if.sv
// formula_pipe_credit_adapter_if: upstream, pipe issue/result and downstream signals of the credit adapter.
interface formula_pipe_credit_adapter_if #(parameter int W = formula_pipe_pkg::W);
    logic up_vld, up_rdy;
    logic [W-1:0] up_a, up_b, up_c;
    logic arg_vld;
    logic [W-1:0] a, b, c;
    logic res_vld;
    logic [W-1:0] res;
    logic down_vld, down_rdy;
    logic [W-1:0] down_data;
    modport slave (
        input up_vld, up_a, up_b, up_c, res_vld, res, down_rdy,
        output up_rdy, arg_vld, a, b, c, down_vld, down_data
    );
    modport master (
        output up_vld, up_a, up_b, up_c, res_vld, res, down_rdy,
        input up_rdy, arg_vld, a, b, c, down_vld, down_data
    );
endinterface

// File: rtl/sync_fifo_show_ahead.sv
// sync_fifo_show_ahead: flop-based FIFO whose head entry is always visible on head_data.
module sync_fifo_show_ahead #(
    parameter int W = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign do_pop = pop & !empty;
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign do_push = push & (!full | do_pop);
    assign head_data = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= push_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/formula_pipe_credit_adapter.sv
// formula_pipe_credit_adapter: issues valid/ready argument triples to a stall-free formula pipe and
// buffers its results; credits bound outstanding work so the result FIFO can never overflow.
module formula_pipe_credit_adapter #(
    parameter int W = formula_pipe_pkg::W,
    parameter int DEPTH = formula_pipe_pkg::DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    formula_pipe_credit_adapter_if.slave bus,
    output logic [$clog2(DEPTH):0]   credits,
    output logic [$clog2(DEPTH):0]   in_flight,
    output logic                     err_overflow,
    output logic                     err_unexpected
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic issue, pop, accept, full, empty;
    assign bus.up_rdy = credits != '0;
    assign issue = bus.up_vld & bus.up_rdy;
    assign pop = bus.down_vld & bus.down_rdy;
    // results with nothing outstanding are stale and never reach the FIFO
    assign accept = bus.res_vld & (in_flight != '0);
    assign bus.down_vld = !empty;
    sync_fifo_show_ahead #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(accept),
        .push_data(bus.res),
        .pop(pop),
        .head_data(bus.down_data),
        .empty(empty),
        .full(full)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.arg_vld <= 1'b0;
            bus.a <= '0;
            bus.b <= '0;
            bus.c <= '0;
            credits <= CW'(DEPTH);
            in_flight <= '0;
            err_overflow <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            bus.arg_vld <= issue;
            if (issue) begin
                bus.a <= bus.up_a;
                bus.b <= bus.up_b;
                bus.c <= bus.up_c;
            end
            credits <= credits + CW'(pop) - CW'(issue);
            in_flight <= in_flight + CW'(issue) - CW'(accept);
            if (accept & full & !pop) err_overflow <= 1'b1;
            if (bus.res_vld & (in_flight == '0)) err_unexpected <= 1'b1;
        end
    end
endmodule

// File: tb/tb_formula_pipe_credit_adapter.sv
// tb_formula_pipe_credit_adapter: scoreboard bench driving a DEPTH=8/L=5 and a DEPTH=16/L=10 adapter
// in front of a behavioural formula_2 pipe.
module tb_formula_pipe_credit_adapter;
    import formula_pipe_pkg::*;
    typedef struct { word_t a, b, c; } trip_t;
    logic clk, rst, inj;
    logic [3:0] cr8, if8;
    logic [4:0] cr16, if16;
    logic e8o, e8u, e16o, e16u;
    int checks = 0, errors = 0;
    int acc8 = 0, pops8 = 0, acc16 = 0, outs16 = 0, gaps16 = 0, drops16 = 0;
    word_t exp8[$], exp16[$];
    trip_t t [12];
    bit done;
    formula_pipe_credit_adapter_if #(.W(W)) f8 ();
    formula_pipe_credit_adapter_if #(.W(W)) f16 ();
    formula_pipe_credit_adapter #(.W(W), .DEPTH(8)) u8 (
        .clk(clk), .rst(rst), .bus(f8), .credits(cr8), .in_flight(if8),
        .err_overflow(e8o), .err_unexpected(e8u)
    );
    formula_pipe_credit_adapter #(.W(W), .DEPTH(16)) u16 (
        .clk(clk), .rst(rst), .bus(f16), .credits(cr16), .in_flight(if16),
        .err_overflow(e16o), .err_unexpected(e16u)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    function automatic word_t f2(input word_t x, input word_t y, input word_t z);
        return (x < z) ? x * y : z;
    endfunction
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // behavioural pipes: fixed latency, no stall, flushed by the shared reset
    logic [4:0] v8;
    word_t d8 [5];
    logic [9:0] v16;
    word_t d16 [10];
    always @(posedge clk) begin
        if (rst) begin
            v8 <= '0;
            v16 <= '0;
        end else begin
            v8 <= {v8[3:0], f8.arg_vld};
            v16 <= {v16[8:0], f16.arg_vld};
        end
        d8[0] <= f2(f8.a, f8.b, f8.c);
        d16[0] <= f2(f16.a, f16.b, f16.c);
        for (int i = 1; i < 5; i++) d8[i] <= d8[i-1];
        for (int i = 1; i < 10; i++) d16[i] <= d16[i-1];
    end
    assign f8.res_vld = v8[4] | inj;
    assign f8.res = d8[4];
    assign f16.res_vld = v16[9];
    assign f16.res = d16[9];
    always @(negedge clk) begin
        if (!rst) begin
            if (!e8o && !e8u) chk("inv8", 64'(int'(cr8) + exp8.size()), 64'(8));
            if (f8.down_vld && f8.down_rdy) begin
                if (exp8.size() == 0) chk("out8_extra", 64'(exp8.size()), 64'(1));
                else chk("out8", f8.down_data, exp8.pop_front());
                pops8++;
            end
            if (f8.up_vld && f8.up_rdy) begin
                exp8.push_back(f2(f8.up_a, f8.up_b, f8.up_c));
                acc8++;
            end
            if (!e16o && !e16u) chk("inv16", 64'(int'(cr16) + exp16.size()), 64'(16));
            if (outs16 > 0 && outs16 < 200 && !f16.down_vld) gaps16++;
            if (f16.down_vld && f16.down_rdy) begin
                if (exp16.size() == 0) chk("out16_extra", 64'(exp16.size()), 64'(1));
                else chk("out16", f16.down_data, exp16.pop_front());
                outs16++;
            end
            if (f16.up_vld && f16.up_rdy) begin
                exp16.push_back(f2(f16.up_a, f16.up_b, f16.up_c));
                acc16++;
            end
        end
    end
    task automatic send(input word_t x, input word_t y, input word_t z);
        int n = 0;
        f8.up_vld = 1;
        f8.up_a = x;
        f8.up_b = y;
        f8.up_c = z;
        @(negedge clk);
        while (!f8.up_rdy && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!f8.up_rdy) chk("send_timeout", 64'(f8.up_rdy), 64'(1));
        @(posedge clk);
        #1;
    endtask
    task automatic drain8();
        int n = 0;
        while (exp8.size() != 0 && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("drain8", 64'(exp8.size()), 64'(0));
    endtask
    task automatic chk_reset8(input string tag);
        chk({tag, "_up_rdy"}, 64'(f8.up_rdy), 64'(1));
        chk({tag, "_credits"}, 64'(cr8), 64'(8));
        chk({tag, "_in_flight"}, 64'(if8), 64'(0));
        chk({tag, "_down_vld"}, 64'(f8.down_vld), 64'(0));
        chk({tag, "_arg_vld"}, 64'(f8.arg_vld), 64'(0));
        chk({tag, "_a"}, 64'(f8.a), 64'(0));
        chk({tag, "_err_ovf"}, 64'(e8o), 64'(0));
        chk({tag, "_err_unexp"}, 64'(e8u), 64'(0));
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        rst = 1;
        inj = 0;
        {f8.up_vld, f8.up_a, f8.up_b, f8.up_c} = '0;
        {f16.up_vld, f16.up_a, f16.up_b, f16.up_c} = '0;
        f8.down_rdy = 1;
        f16.down_rdy = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk_reset8("rst");
        chk("rst16_credits", 64'(cr16), 64'(16));
        chk("rst16_up_rdy", 64'(f16.up_rdy), 64'(1));
        // full rate on the deep instance
        for (int k = 0; k < 200; k++) begin
            f16.up_vld = 1;
            f16.up_a = $urandom;
            f16.up_b = $urandom;
            f16.up_c = $urandom;
            @(negedge clk);
            if (!f16.up_rdy) drops16++;
            @(posedge clk);
            #1;
        end
        f16.up_vld = 0;
        for (int n = 0; n < 60 && outs16 < 200; n++) @(posedge clk);
        #1;
        chk("fr_drops", 64'(drops16), 64'(0));
        chk("fr_gaps", 64'(gaps16), 64'(0));
        chk("fr_outs", 64'(outs16), 64'(200));
        chk("fr_acc", 64'(acc16), 64'(200));
        chk("fr_credits", 64'(cr16), 64'(16));
        // single transaction
        send(2, 1, 9);
        f8.up_vld = 0;
        chk("one_arg_vld", 64'(f8.arg_vld), 64'(1));
        chk("one_a", 64'(f8.a), 64'(2));
        chk("one_b", 64'(f8.b), 64'(1));
        chk("one_c", 64'(f8.c), 64'(9));
        @(posedge clk);
        #1;
        chk("one_arg_pulse", 64'(f8.arg_vld), 64'(0));
        chk("one_credits", 64'(cr8), 64'(7));
        for (int n = 0; n < 20 && !f8.down_vld; n++) begin
            @(posedge clk);
            #1;
        end
        chk("one_down_vld", 64'(f8.down_vld), 64'(1));
        chk("one_data", 64'(f8.down_data), 64'(2));
        @(posedge clk);
        #1;
        chk("one_credit_back", 64'(cr8), 64'(8));
        // stalled downstream
        t[0] = '{14, 7, 4};
        for (int k = 1; k < 12; k++) t[k] = '{$urandom, $urandom, $urandom};
        f8.down_rdy = 0;
        for (int k = 0; k < 8; k++) send(t[k].a, t[k].b, t[k].c);
        f8.up_a = t[8].a;
        f8.up_b = t[8].b;
        f8.up_c = t[8].c;
        repeat (12) @(posedge clk);
        #1;
        chk("stall_acc", 64'(acc8), 64'(9));
        chk("stall_up_rdy", 64'(f8.up_rdy), 64'(0));
        chk("stall_credits", 64'(cr8), 64'(0));
        chk("stall_in_flight", 64'(if8), 64'(0));
        chk("stall_down_vld", 64'(f8.down_vld), 64'(1));
        chk("stall_head", 64'(f8.down_data), 64'(4));
        chk("stall_err_ovf", 64'(e8o), 64'(0));
        // zero credits with a pop: the freed credit issues one cycle later
        f8.down_rdy = 1;
        @(negedge clk);
        chk("bnd_rdy0", 64'(f8.up_rdy), 64'(0));
        @(posedge clk);
        #1;
        chk("bnd_noissue", 64'(f8.arg_vld), 64'(0));
        chk("bnd_rdy1", 64'(f8.up_rdy), 64'(1));
        @(posedge clk);
        #1;
        chk("bnd_issue", 64'(f8.arg_vld), 64'(1));
        chk("bnd_a", 64'(f8.a), 64'(t[8].a));
        for (int k = 9; k < 12; k++) send(t[k].a, t[k].b, t[k].c);
        f8.up_vld = 0;
        drain8();
        chk("stall_total", 64'(acc8), 64'(13));
        chk("stall_pops", 64'(pops8), 64'(13));
        // random downstream readiness
        done = 0;
        fork
            begin
                for (int k = 0; k < 1000; k++) send($urandom, $urandom, $urandom);
                f8.up_vld = 0;
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 f8.down_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        f8.down_rdy = 1;
        drain8();
        chk("rnd_balance", 64'(pops8), 64'(acc8));
        chk("rnd_count", 64'(acc8), 64'(1013));
        chk("rnd_credits", 64'(cr8), 64'(8));
        // stale result with nothing in flight
        @(posedge clk);
        #1 inj = 1;
        @(posedge clk);
        #1 inj = 0;
        chk("unexp_flag", 64'(e8u), 64'(1));
        chk("unexp_in_flight", 64'(if8), 64'(0));
        chk("unexp_ovf", 64'(e8o), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("unexp_nopush", 64'(f8.down_vld), 64'(0));
        chk("unexp_sticky", 64'(e8u), 64'(1));
        // reset with 5 in flight and 3 queued
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        chk("rst2_err_unexp", 64'(e8u), 64'(0));
        f8.down_rdy = 0;
        for (int k = 0; k < 8; k++) send($urandom, $urandom, $urandom);
        f8.up_vld = 0;
        @(posedge clk);
        #1;
        chk("mid_in_flight", 64'(if8), 64'(5));
        chk("mid_credits", 64'(cr8), 64'(0));
        chk("mid_down_vld", 64'(f8.down_vld), 64'(1));
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        exp8.delete();
        chk_reset8("mid_rst");
        f8.down_rdy = 1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_quiet", 64'(f8.down_vld), 64'(0));
        chk("post_rst_unexp", 64'(e8u), 64'(0));
        chk("post_rst_credits", 64'(cr8), 64'(8));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
